uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, gives the tick pulses per bit period; legal values are even and from 4 to 32.
REQ-002 clk  input  1  fpga clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 tick  input  1  one-clk-wide oversample strobe at OVERSAMPLE x baud; the FSM advances only on cycles with tick=1.
REQ-005 rx  input  1  serial line; idle high; LSB first; 8N1, or 8E1 when parity is compiled in.
REQ-006 dados_recebidos  output  8  last received byte, registered.
REQ-007 rd_valid  output  1  one-clk pulse: a good frame has been received and dados_recebidos is valid.
REQ-008 frame_err  output  1  one-clk pulse: the stop bit was sampled as 0.
REQ-009 parity_err  output  1  one-clk pulse: the parity bit mismatched.
REQ-010 rxBusy  output  1  high whenever the FSM is not in STAGE_IDLE.

Function
REQ-011 rx shall pass through a 2-flop synchronizer before any use; both flops reset to 1; the synchronizer adds 2 clk of latency.
REQ-012 The FSM states shall be STAGE_IDLE, STAGE_START, STAGE_WORK, STAGE_PARITY and STAGE_STOP.
REQ-013 A 5-bit tick counter shall count ticks within a bit; a 3-bit bit counter shall index the data bits.
REQ-014 STAGE_IDLE: on a tick with synced rx=0, go to STAGE_START and clear the tick counter.
REQ-015 STAGE_START: at tick count OVERSAMPLE/2-1 (mid start bit), if rx=0 clear the counters and go to STAGE_WORK.
REQ-016 STAGE_START: at the same sample, if rx=1 treat it as a false start, return to STAGE_IDLE and raise no flag.
REQ-017 STAGE_WORK: every OVERSAMPLE ticks (mid bit), shift the sampled rx into shift register bit [bit counter].
REQ-018 STAGE_WORK: after bit 7 is sampled, go to STAGE_PARITY if RX_PARITY_EN is defined, else to STAGE_STOP.
REQ-019 STAGE_PARITY: at mid bit, compare the sample with the XOR of the 8 data bits (even parity); store the mismatch result; go to STAGE_STOP.
REQ-020 STAGE_STOP: at mid stop bit, load dados_recebidos from the shift register and return to STAGE_IDLE at that same cycle.
REQ-021 The early return to STAGE_IDLE at mid stop bit allows back-to-back frames with no idle gap.
REQ-022 Stop sample 1 with no parity mismatch: pulse rd_valid for exactly 1 clk on the following clk edge.
REQ-023 Stop sample 0: pulse frame_err and suppress rd_valid.
REQ-024 Stop sample 1 with a parity mismatch: pulse parity_err and suppress rd_valid.
REQ-025 If the stop bit is 0 and parity also mismatched, frame_err and parity_err shall pulse together.
REQ-026 dados_recebidos shall update on every completed frame, including errored frames, and hold otherwise.
REQ-027 A break (rx held low) shall produce one frame_err, then no new start until rx has returned high for at least one tick.
REQ-028 Cycles with tick=0 shall leave the state and counters unchanged; no output changes except pulse deassertion.
REQ-029 Any illegal state encoding shall return the FSM to STAGE_IDLE on the next clk.

Reset
REQ-030 While rst_n=0 the block shall hold: state STAGE_IDLE, counters 0, shift register 0x00, dados_recebidos 0x00.
REQ-031 While rst_n=0 rd_valid, frame_err, parity_err and rxBusy shall be 0, and both synchronizer flops 1.
REQ-032 Reset asserted mid-frame shall discard the partial byte with no flag pulses; reception restarts on the next falling edge after release.

Configuration
REQ-033 The macro shall be RX_PARITY_EN.
REQ-034 With RX_PARITY_EN defined, the frame is 8E1: STAGE_PARITY is used and parity_err is driven per REQ-019 and REQ-024.
REQ-035 Without RX_PARITY_EN, the frame is 8N1: STAGE_PARITY is unreachable, no parity logic is synthesized, and parity_err is tied to 0.

Verification
REQ-036 Reset, then an 8N1 frame with byte 0xA5 at OVERSAMPLE=16 -> rd_valid single pulse, dados_recebidos=0xA5, no error flags, rxBusy low after mid stop bit.
REQ-037 A 0-pulse on rx of 4 ticks, then rx high -> no rd_valid, no flags, FSM back in STAGE_IDLE, rxBusy pulses high then low.
REQ-038 A frame with byte 0x3C and stop bit 0 -> frame_err pulse, no rd_valid, dados_recebidos=0x3C.
REQ-039 Frames 0x00, 0xFF, 0x55 sent back-to-back with no idle gap -> three rd_valid pulses with matching bytes in order.
REQ-040 With RX_PARITY_EN defined: byte 0x01 with parity bit 1 -> rd_valid; byte 0x01 with parity bit 0 -> parity_err, no rd_valid.
REQ-041 rst_n pulsed low at data bit 4 of byte 0x81 -> no flags, dados_recebidos=0x00; the next frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampled UART receiver, 8N1 (8E1 when RX_PARITY_EN is defined); rx passes a 2-flop synchronizer.
// Latency: flags pulse the clk after the mid-stop-bit tick; no backpressure, each pulse lasts one clk.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       rx,
  output logic [7:0] dados_recebidos,
  output logic       rd_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rxBusy
);

  localparam logic [4:0] HALF_LAST = 5'(OVERSAMPLE / 2 - 1);
  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    STAGE_IDLE   = 3'd0,
    STAGE_START  = 3'd1,
    STAGE_WORK   = 3'd2,
    STAGE_PARITY = 3'd3,
    STAGE_STOP   = 3'd4
  } stage_t;

  logic       rx_meta;
  logic       rx_sync;
  stage_t     state_q,    state_d;
  logic [4:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q,  bit_cnt_d;
  logic [7:0] shreg_q,    shreg_d;
  logic [7:0] data_d;
  logic       hold_q,     hold_d;
  logic       valid_d;
  logic       ferr_d;
`ifdef RX_PARITY_EN
  logic       par_bad_q,  par_bad_d;
  logic       perr_d;
  logic       perr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= STAGE_IDLE;
      tick_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shreg_q         <= '0;
      hold_q          <= 1'b0;
      dados_recebidos <= '0;
      rd_valid        <= 1'b0;
      frame_err       <= 1'b0;
`ifdef RX_PARITY_EN
      par_bad_q       <= 1'b0;
      perr_q          <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shreg_q         <= shreg_d;
      hold_q          <= hold_d;
      dados_recebidos <= data_d;
      rd_valid        <= valid_d;
      frame_err       <= ferr_d;
`ifdef RX_PARITY_EN
      par_bad_q       <= par_bad_d;
      perr_q          <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    hold_d     = hold_q;
    data_d     = dados_recebidos;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
`ifdef RX_PARITY_EN
    par_bad_d  = par_bad_q;
    perr_d     = 1'b0;
`endif
    case (state_q)
      // hold_q blocks a new start after a break until the line has been seen high
      STAGE_IDLE: begin
        if (tick) begin
          if (rx_sync) begin
            hold_d = 1'b0;
          end else if (!hold_q) begin
            state_d    = STAGE_START;
            tick_cnt_d = '0;
          end
        end
      end
      STAGE_START: begin
        if (tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            if (!rx_sync) begin
              state_d    = STAGE_WORK;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = STAGE_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
      STAGE_WORK: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d         = '0;
            shreg_d[bit_cnt_q] = rx_sync;
            if (bit_cnt_q == 3'd7) begin
`ifdef RX_PARITY_EN
              state_d = STAGE_PARITY;
`else
              state_d = STAGE_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
`ifdef RX_PARITY_EN
      STAGE_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            par_bad_d  = rx_sync ^ (^shreg_q);
            state_d    = STAGE_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
`endif
      // Leaving at mid stop bit lets the next start edge follow with no idle gap
      STAGE_STOP: begin
        if (tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            data_d     = shreg_q;
            state_d    = STAGE_IDLE;
            ferr_d     = !rx_sync;
            hold_d     = !rx_sync;
`ifdef RX_PARITY_EN
            perr_d     = par_bad_q;
            valid_d    = rx_sync && !par_bad_q;
`else
            valid_d    = rx_sync;
`endif
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = STAGE_IDLE;
    endcase
  end

`ifdef RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rxBusy = (state_q != STAGE_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are driven on a tick-aligned line; a frame-level outcome model feeds a scoreboard.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int OS = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] dados_recebidos;
  logic       rd_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rxBusy;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick            (tick),
    .rx              (rx),
    .dados_recebidos (dados_recebidos),
    .rd_valid        (rd_valid),
    .frame_err       (frame_err),
    .parity_err      (parity_err),
    .rxBusy          (rxBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        cur;
  logic [7:0] model_last = 8'h00;
  int         total = 0;
  int         bad   = 0;
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_perr  = 0;
  int         div_cnt = 0;
  logic       busy_seen = 1'b0;
  logic       busy_mid  = 1'b0;
  logic       busy_stop = 1'b1;
  int         v0, f0, p0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // one tick every third clk, changed on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      tick = (div_cnt == 2);
      div_cnt = (div_cnt == 2) ? 0 : div_cnt + 1;
    end
  end

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
    #1;
  endtask

  // frame outcome from the line rules: stop 0 -> frame error, parity mismatch -> parity error
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    ev_t e;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == 4) begin
        wait_ticks(OS / 2);
        busy_mid = rxBusy;
        wait_ticks(OS / 2);
      end else begin
        wait_ticks(OS);
      end
    end
`ifdef RX_PARITY_EN
    rx = (^d) ^ par_flip;
    e.pe = (rx != (^d));
    wait_ticks(OS);
`else
    e.pe = 1'b0;
    if (par_flip) e.pe = 1'b0;
`endif
    e.fe = !stop;
    e.v  = stop && !e.pe;
    e.d  = d;
    exp_q.push_back(e);
    rx = stop;
    wait_ticks(12);
    busy_stop = rxBusy;
    wait_ticks(OS - 12);
  endtask

  task automatic snap;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
  endtask

  // compare process: every cycle against the scoreboard / held-byte model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_last = 8'h00;
        exp_q.delete();
        check("reset_outs", {28'd0, rd_valid, frame_err, parity_err, rxBusy}, 32'd0);
        check("reset_data", {24'd0, dados_recebidos}, 32'd0);
      end else begin
        if (rxBusy) busy_seen = 1'b1;
        if (rd_valid)   n_valid++;
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
        if (rd_valid || frame_err || parity_err) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse got=%b%b%b want=none at %0t", rd_valid, frame_err, parity_err, $time);
          end else begin
            cur = exp_q.pop_front();
            check("pulse_flags", {29'd0, rd_valid, frame_err, parity_err}, {29'd0, cur.v, cur.fe, cur.pe});
            check("pulse_data", {24'd0, dados_recebidos}, {24'd0, cur.d});
            model_last = cur.d;
          end
        end else begin
          check("data_hold", {24'd0, dados_recebidos}, {24'd0, model_last});
        end
      end
    end
  end

  initial begin
    #3_000_000;
    bad++;
    $display("FAIL timeout got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [7:0] b;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, rxBusy}, 32'd0);
    check("rst_data", {24'd0, dados_recebidos}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ticks(20);

    // good 8N1 frame
    snap();
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_ticks(4);
    check("a5_data", {24'd0, dados_recebidos}, 32'h0000_00A5);
    check("a5_valid_cnt", n_valid - v0, 1);
    check("a5_err_cnt", (n_ferr - f0) + (n_perr - p0), 0);
    check("a5_busy_mid", {31'd0, busy_mid}, 32'd1);
    check("a5_busy_after_stop", {31'd0, busy_stop}, 32'd0);

    // 4-tick glitch: false start
    snap();
    busy_seen = 1'b0;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(24);
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_now", {31'd0, rxBusy}, 32'd0);
    check("glitch_pulses", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);

    // stop bit 0
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b1;
    wait_ticks(OS);
    check("3c_ferr_cnt", n_ferr - f0, 1);
    check("3c_valid_cnt", n_valid - v0, 0);
    check("3c_data", {24'd0, dados_recebidos}, 32'h0000_003C);

    // break: line held low well past one frame
    snap();
    send_frame(8'h00, 1'b0, 1'b0);
    wait_ticks(40);
    check("break_busy", {31'd0, rxBusy}, 32'd0);
    rx = 1'b1;
    wait_ticks(OS);
    check("break_ferr_cnt", n_ferr - f0, 1);
    check("break_valid_cnt", n_valid - v0, 0);

    // back-to-back frames, no idle gap
    snap();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    wait_ticks(4);
    check("b2b_valid_cnt", n_valid - v0, 3);
    check("b2b_last_data", {24'd0, dados_recebidos}, 32'h0000_0055);

    // reset in the middle of data bit 4 of 0x81
    snap();
    b = 8'h81;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_ticks(OS);
    end
    rx = b[4];
    wait_ticks(OS / 2);
    check("rstmid_busy", {31'd0, rxBusy}, 32'd1);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ticks(20);
    check("rstmid_data", {24'd0, dados_recebidos}, 32'd0);
    check("rstmid_flags", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
    send_frame(8'h7E, 1'b1, 1'b0);
    wait_ticks(4);
    check("7e_data", {24'd0, dados_recebidos}, 32'h0000_007E);
    check("7e_valid_cnt", n_valid - v0, 1);

`ifdef RX_PARITY_EN
    snap();
    send_frame(8'h01, 1'b1, 1'b0);
    wait_ticks(4);
    check("par_ok_valid", n_valid - v0, 1);
    check("par_ok_perr", n_perr - p0, 0);
    snap();
    send_frame(8'h01, 1'b1, 1'b1);
    wait_ticks(4);
    check("par_bad_perr", n_perr - p0, 1);
    check("par_bad_valid", n_valid - v0, 0);
    check("par_bad_data", {24'd0, dados_recebidos}, 32'h0000_0001);
`endif

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
